// File: rtl/instr_fetch_reg_pkg.sv
// Shared definitions for the MIPS fetch stage: control state encoding,
// instruction-register field positions and the default reset PC.
package instr_fetch_reg_pkg;

  // Fetch control states; encodings are fixed so debug taps stay comparable.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ERR   = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction register field positions (MSB/LSB).
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/instr_fetch_reg_timeout_counter.sv
// Counts cycles spent waiting for memory during a fetch and flags the last
// permitted wait cycle, so the controller can give up on a dead memory.
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  output logic [TO_W-1:0] count,
  output logic            expired
);

  // Clear wins over enable so a freshly started fetch always begins at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // High during the final wait cycle; no ready in this cycle means timeout.
  assign expired = (count == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instr_fetch_reg.sv
// Fetch stage of the multi-cycle MIPS datapath: holds the PC, performs a
// valid/ready instruction read, latches the word into the IR and splits it
// into opcode / rs / rt / immediate fields.
//
// Memory handshake: mem_req is the request valid and is high for every cycle
// the stage is in FETCH; mem_addr is latched when the fetch starts and stays
// stable while mem_req is high. A transfer completes in any cycle where
// mem_req and mem_ready are both high; mem_rdata is sampled at the end of that
// cycle. The memory must not assert mem_ready expecting a transfer when
// mem_req is low (it is ignored).
module instr_fetch_reg
  import instr_fetch_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int          PC_STEP        = 4,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          TO_W           = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_write,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic        ir_valid,
  output logic        busy,
  output logic        fetch_timeout,
  output logic [5:0]  IR31_26,
  output logic [4:0]  IR25_21,
  output logic [4:0]  IR20_16,
  output logic [15:0] IR15_0,
  output logic [1:0]  state_dbg
);

  fetch_state_t     state;
  logic [31:0]      ir;
  logic             start_fetch;
  logic             capture;
  logic             wait_cycle;
  logic [TO_W-1:0]  to_count;
  logic             to_expired;

  // A start request is only honoured when no fetch is in flight.
  assign start_fetch = fetch_start && (state != ST_FETCH);
  assign capture     = (state == ST_FETCH) && mem_ready;
  assign wait_cycle  = (state == ST_FETCH) && !mem_ready;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_fetch),
    .enable  (wait_cycle),
    .count   (to_count),
    .expired (to_expired)
  );

  // PC: an explicit redirect always wins over the post-fetch increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (pc_write) begin
      pc <= pc_next;
    end else if (capture) begin
      pc <= pc + 32'(PC_STEP);
    end
  end

  // Control FSM with the address latch, IR capture and valid flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      ir       <= '0;
      ir_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ERR: begin
          if (fetch_start) begin
            state    <= ST_FETCH;
            mem_addr <= pc;
            ir_valid <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (mem_ready) begin
            ir       <= mem_rdata;
            ir_valid <= 1'b1;
            state    <= ST_IDLE;
          end else if (to_expired) begin
            state <= ST_ERR;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decode directly from the state register.
  assign mem_req       = (state == ST_FETCH);
  assign busy          = (state == ST_FETCH);
  assign fetch_timeout = (state == ST_ERR);
  assign state_dbg     = state;

  // IR fields are plain slices; they only move when the IR is recaptured.
  assign IR31_26 = ir[OP_MSB:OP_LSB];
  assign IR25_21 = ir[RS_MSB:RS_LSB];
  assign IR20_16 = ir[RT_MSB:RT_LSB];
  assign IR15_0  = ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Bench for the fetch stage: directed vector table, hand-written multi-cycle
// corner cases, then randomized traffic against a cycle-level reference model.
module tb_instr_fetch_reg;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] pc;
  logic        ir_valid;
  logic        busy;
  logic        fetch_timeout;
  logic [5:0]  IR31_26;
  logic [4:0]  IR25_21;
  logic [4:0]  IR20_16;
  logic [15:0] IR15_0;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  instr_fetch_reg dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_start   (fetch_start),
    .pc_write      (pc_write),
    .pc_next       (pc_next),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .pc            (pc),
    .ir_valid      (ir_valid),
    .busy          (busy),
    .fetch_timeout (fetch_timeout),
    .IR31_26       (IR31_26),
    .IR25_21       (IR25_21),
    .IR20_16       (IR20_16),
    .IR15_0        (IR15_0),
    .state_dbg     (state_dbg)
  );

  int checks = 0;
  int passes = 0;

  // Control must never redirect and start in the same idle cycle.
  always @(posedge clk) begin
    if (!reset && fetch_start && pc_write && !busy)
      $error("illegal fetch_start with pc_write while not busy");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic fs, input logic pw, input logic [31:0] pn,
                       input logic rdy, input logic [31:0] rd);
    fetch_start = fs;
    pc_write    = pw;
    pc_next     = pn;
    mem_ready   = rdy;
    mem_rdata   = rd;
  endtask

  // Apply inputs, then sample 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Full check of all externally visible state against expected values.
  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_req,
                           input logic [31:0] e_addr, input logic [31:0] e_ir,
                           input logic e_irv, input logic e_to);
    logic [31:0] fields;
    fields = {IR31_26, IR25_21, IR20_16, IR15_0};
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".req"}, {31'b0, mem_req}, {31'b0, e_req});
    check({tag, ".busy"}, {31'b0, busy}, {31'b0, e_req});
    if (e_req) check({tag, ".addr"}, mem_addr, e_addr);
    check({tag, ".ir"}, fields, e_ir);
    check({tag, ".irv"}, {31'b0, ir_valid}, {31'b0, e_irv});
    check({tag, ".to"}, {31'b0, fetch_timeout}, {31'b0, e_to});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fs;
    logic        pw;
    logic [31:0] pn;
    logic        rdy;
    logic [31:0] rd;
    logic [31:0] e_pc;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_ir;
    logic        e_irv;
  } vec_t;

  vec_t vecs[11];

  // ---------------- reference model ----------------
  int          m_st;      // 0 idle, 1 fetching, 2 timed out
  int          m_waited;  // cycles spent in the current fetch without ready
  logic [31:0] m_pc, m_addr, m_ir;
  logic        m_irv;
  logic [31:0] exp_q[$];

  task automatic model_step(input logic fs, input logic pw, input logic [31:0] pn,
                            input logic rdy, input logic [31:0] rd);
    logic [31:0] npc;
    npc = m_pc;
    if (pw) npc = pn;
    else if (m_st == 1 && rdy) npc = m_pc + 32'd4;
    if (m_st != 1 && fs) begin
      m_st = 1; m_addr = m_pc; m_waited = 0; m_irv = 1'b0;
    end else if (m_st == 1) begin
      if (rdy) begin
        m_ir = rd; m_irv = 1'b1; m_st = 0;
      end else begin
        m_waited++;
        if (m_waited == 16) m_st = 2;
      end
    end
    m_pc = npc;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] last_ir;
    int hold_off;
    reset = 1'b1;
    idle_inputs();
    #2;

    // Reset state.
    tick();
    check_all("reset", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("reset.state", {30'b0, state_dbg}, 32'd0);
    reset = 1'b0;
    tick();

    //          fs    pw    pn            rdy   rd             e_pc          req   addr          ir             irv
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         32'h0,        1'b1, 32'h0,        32'h0,         1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h2008_FFFF, 32'h4,        1'b0, 32'h0,        32'h2008_FFFF, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'h40,       1'b0, 32'h0,         32'h40,       1'b0, 32'h0,        32'h2008_FFFF, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         32'h40,       1'b1, 32'h40,       32'h2008_FFFF, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'hDEAD_BEEF, 32'h40,       1'b1, 32'h40,       32'h2008_FFFF, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'hDEAD_BEEF, 32'h40,       1'b1, 32'h40,       32'h2008_FFFF, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'hDEAD_BEEF, 32'h40,       1'b1, 32'h40,       32'h2008_FFFF, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8C43_0010, 32'h44,       1'b0, 32'h40,       32'h8C43_0010, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         32'h44,       1'b1, 32'h44,       32'h8C43_0010, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         32'h44,       1'b1, 32'h44,       32'h8C43_0010, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h100,      1'b1, 32'h1234_5678, 32'h100,      1'b0, 32'h44,       32'h1234_5678, 1'b1};

    for (int i = 0; i < 11; i++) begin
      // Address must hold across the whole request, including the completing cycle.
      if (mem_req) check($sformatf("vec%0d.addr_hold", i), mem_addr, vecs[i].e_addr);
      drive(vecs[i].fs, vecs[i].pw, vecs[i].pn, vecs[i].rdy, vecs[i].rd);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_req, vecs[i].e_addr,
                vecs[i].e_ir, vecs[i].e_irv, 1'b0);
    end
    idle_inputs();
    check("fields.op", {26'b0, IR31_26}, 32'h04);
    check("fields.imm", {16'b0, IR15_0}, 32'h5678);

    // Asynchronous reset in the middle of a fetch.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    idle_inputs();
    check("rstmid.req_before", {31'b0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_all("rstmid", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // Timeout: memory never answers.
    drive(1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    idle_inputs();
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("to.busy%0d", i), {31'b0, busy}, 32'd1);
    end
    tick();
    check_all("to.err", 32'h200, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("to.state", {30'b0, state_dbg}, 32'd2);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    check_all("to.retry", 32'h200, 1'b1, 32'h200, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hAC22_0008);
    tick();
    check_all("to.done", 32'h204, 1'b0, 32'h0, 32'hAC22_0008, 1'b1, 1'b0);

    // PC wrap plus a start request while busy.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    check_all("wrap.ignore", 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'hAC22_0008, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0001);
    tick();
    check_all("wrap.done", 32'h0, 1'b0, 32'h0, 32'h0000_0001, 1'b1, 1'b0);
    idle_inputs();

    // Randomized traffic against the reference model.
    do_reset();
    m_st = 0; m_waited = 0; m_pc = 32'h0; m_addr = 32'h0; m_ir = 32'h0; m_irv = 1'b0;
    hold_off = 0;
    for (int c = 0; c < 1500; c++) begin
      logic fs, pw, rdy;
      logic [31:0] pn, rd;
      fs  = ($urandom_range(0, 3) == 0);
      pw  = ($urandom_range(0, 9) == 0);
      pn  = {$urandom_range(0, 32'hFFFF), 14'b0, 2'b00} | ($urandom_range(0, 1) ? 32'hFFFF_0000 : 32'h0);
      rd  = $urandom;
      if (m_st != 1 && fs) begin
        pw = 1'b0;
        hold_off = ($urandom_range(0, 5) == 0) ? 20 : 0;
      end
      rdy = (hold_off == 0) && ($urandom_range(0, 2) == 0);
      if (hold_off > 0) hold_off--;
      model_step(fs, pw, pn, rdy, rd);
      exp_q.push_back(m_pc);
      drive(fs, pw, pn, rdy, rd);
      tick();
      check($sformatf("rnd%0d.pc", c), pc, exp_q.pop_front());
      check($sformatf("rnd%0d.req", c), {31'b0, mem_req}, {31'b0, m_st == 1});
      check($sformatf("rnd%0d.to", c), {31'b0, fetch_timeout}, {31'b0, m_st == 2});
      check($sformatf("rnd%0d.irv", c), {31'b0, ir_valid}, {31'b0, m_irv});
      last_ir = {IR31_26, IR25_21, IR20_16, IR15_0};
      check($sformatf("rnd%0d.ir", c), last_ir, m_ir);
      if (m_st == 1) check($sformatf("rnd%0d.addr", c), mem_addr, m_addr);
    end
    idle_inputs();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
